// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths, range helper.
// Used by both the master stage and the register-file completer.
package apb_pkg;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;

   localparam int ADDR_W_DEF = 3;
   localparam int DATA_W_DEF = 16;

   function automatic logic in_range(input int unsigned a,
                                     input int unsigned n);
      return a < n;
   endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between master stage and completer.
// Pslverr exists only when APB_SLV_PSLVERR_EN is defined.
interface apb_slave_regfile_if
   import apb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              Pselx;
   logic              Penable;
   logic              Pwrite;
   logic [ADDR_W-1:0] Paddr;
   logic [DATA_W-1:0] Pwdata;
   logic [DATA_W-1:0] Prdata;
   logic              Pready;
`ifdef APB_SLV_PSLVERR_EN
   logic              Pslverr;

   modport master (
      output Pselx, Penable, Pwrite, Paddr, Pwdata,
      input  Prdata, Pready, Pslverr
   );

   modport slave (
      input  Pselx, Penable, Pwrite, Paddr, Pwdata,
      output Prdata, Pready, Pslverr
   );
`else
   modport master (
      output Pselx, Penable, Pwrite, Paddr, Pwdata,
      input  Prdata, Pready
   );

   modport slave (
      input  Pselx, Penable, Pwrite, Paddr, Pwdata,
      output Prdata, Pready
   );
`endif

endinterface

// File: rtl/apb_wait_counter.sv
// Access-phase wait-state counter: load on setup, count down while stalled.
// The zero flag is purely registered so Pready has no input-to-output path.
module apb_wait_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   input  logic         clr,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of DATA_W-bit registers and fixed wait states.
// Optional Pslverr on out-of-range addresses under APB_SLV_PSLVERR_EN.
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int NUM_REGS    = 6,
   parameter int WAIT_CYCLES = 0
) (
   input logic               Pclk,
   input logic               Prst,
   apb_slave_regfile_if.slave bus
);

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   logic              setup;
   logic              access;
   logic              cnt_load;
   logic              cnt_dec;
   logic              cnt_clr;
   logic              cnt_zero;
   logic              ready;
   logic              addr_ok;
   logic [DATA_W-1:0] rd_sel;

   assign setup   = bus.Pselx & ~bus.Penable;
   assign access  = bus.Pselx & bus.Penable;
   assign addr_ok = in_range(32'(addr_q), NUM_REGS);

   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (bus.Paddr == ADDR_W'(i)) rd_sel = regs_q[i];
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wr_d     = wr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      regs_d   = regs_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_clr  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (setup) begin
               state_d  = ST_ACCESS;
               addr_d   = bus.Paddr;
               wr_d     = bus.Pwrite;
               wdata_d  = bus.Pwdata;
               rdata_d  = rd_sel;
               cnt_load = 1'b1;
            end
         end
         ST_ACCESS: begin
            if (!bus.Pselx) begin
               state_d = ST_IDLE;
               cnt_clr = 1'b1;
            end else if (access) begin
               if (!cnt_zero) begin
                  cnt_dec = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  // Out-of-range writes fall through the loop untouched
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (wr_q && (addr_q == ADDR_W'(i))) regs_d[i] = wdata_q;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Pclk) begin
      if (Prst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         regs_q  <= regs_d;
      end
   end

   apb_wait_counter #(.W(4)) u_wait (
      .clk      (Pclk),
      .rst      (Prst),
      .load     (cnt_load),
      .load_val (4'(WAIT_CYCLES)),
      .dec      (cnt_dec),
      .clr      (cnt_clr),
      .zero     (cnt_zero)
   );

   assign ready      = (state_q == ST_ACCESS) & cnt_zero;
   assign bus.Pready = ready;
   assign bus.Prdata = (ready && !wr_q) ? rdata_q : '0;

`ifdef APB_SLV_PSLVERR_EN
   assign bus.Pslverr = ready & ~addr_ok;
`else
   logic unused_ok;
   assign unused_ok = addr_ok;
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench: three completers (0, 3 and 2 wait states) on a shared driver,
// directed table + corner sequences + random traffic against a memory model.
module tb_apb_slave_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        p_sel, p_en, p_wr;
   logic [2:0]  p_addr;
   logic [15:0] p_wdata;
   int          tgt;
   int          cyc = 0;

   logic        rdy;
   logic [15:0] rdata;
   logic        err;

   int          nvec = 0;
   int          nerr = 0;

   int          wcfg [3] = '{0, 3, 2};
   logic [15:0] mem [3][8];

   apb_slave_regfile_if #(.ADDR_W(3), .DATA_W(16)) bus0 ();
   apb_slave_regfile_if #(.ADDR_W(3), .DATA_W(16)) bus1 ();
   apb_slave_regfile_if #(.ADDR_W(3), .DATA_W(16)) bus2 ();

   apb_slave_regfile #(.WAIT_CYCLES(0)) dut0 (
      .Pclk(clk), .Prst(rst), .bus(bus0.slave));
   apb_slave_regfile #(.WAIT_CYCLES(3)) dut1 (
      .Pclk(clk), .Prst(rst), .bus(bus1.slave));
   apb_slave_regfile #(.WAIT_CYCLES(2)) dut2 (
      .Pclk(clk), .Prst(rst), .bus(bus2.slave));

   assign bus0.Pselx   = p_sel && (tgt == 0);
   assign bus1.Pselx   = p_sel && (tgt == 1);
   assign bus2.Pselx   = p_sel && (tgt == 2);
   assign bus0.Penable = p_en;
   assign bus1.Penable = p_en;
   assign bus2.Penable = p_en;
   assign bus0.Pwrite  = p_wr;
   assign bus1.Pwrite  = p_wr;
   assign bus2.Pwrite  = p_wr;
   assign bus0.Paddr   = p_addr;
   assign bus1.Paddr   = p_addr;
   assign bus2.Paddr   = p_addr;
   assign bus0.Pwdata  = p_wdata;
   assign bus1.Pwdata  = p_wdata;
   assign bus2.Pwdata  = p_wdata;

   always_comb begin
      rdy   = bus0.Pready;
      rdata = bus0.Prdata;
      if (tgt == 1) begin
         rdy   = bus1.Pready;
         rdata = bus1.Prdata;
      end else if (tgt == 2) begin
         rdy   = bus2.Pready;
         rdata = bus2.Prdata;
      end
   end

`ifdef APB_SLV_PSLVERR_EN
   assign err = (tgt == 0) ? bus0.Pslverr :
                (tgt == 1) ? bus1.Pslverr : bus2.Pslverr;
`else
   assign err = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int t = 0; t < 3; t++)
         for (int a = 0; a < 8; a++) mem[t][a] = 16'h0;
   endtask

   // One transfer; returns at the negedge where Pready is seen high.
   task automatic xfer(input int t, input logic w, input logic [2:0] a,
                       input logic [15:0] d, output logic [15:0] rd,
                       output int waits, output logic e, output logic done,
                       output int c0, output int c1);
      @(negedge clk);
      tgt = t; p_sel = 1'b1; p_en = 1'b0;
      p_wr = w; p_addr = a; p_wdata = d;
      c0 = cyc;
      @(negedge clk);
      p_en = 1'b1;
      waits = 0;
      while (!rdy && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      done = rdy;
      rd   = rdata;
      e    = err;
      c1   = cyc + 1;
   endtask

   task automatic idle();
      @(negedge clk);
      p_sel = 1'b0; p_en = 1'b0;
   endtask

   task automatic run(input int t, input logic w, input logic [2:0] a,
                      input logic [15:0] d);
      logic [15:0] rd, exp_rd;
      int          waits, c0, c1;
      logic        e, done;
      xfer(t, w, a, d, rd, waits, e, done, c0, c1);
      exp_rd = (!w && a < 6) ? mem[t][a] : 16'h0;
      chk("rnd_done", 32'(done), 32'(1'b1));
      chk("rnd_waits", 32'(waits), 32'(wcfg[t]));
      chk("rnd_rdata", 32'(rd), 32'(exp_rd));
`ifdef APB_SLV_PSLVERR_EN
      chk("rnd_slverr", 32'(e), 32'(a >= 6));
`endif
      if (w && a < 6) mem[t][a] = d;
   endtask

   typedef struct {
      int          t;
      logic        w;
      logic [2:0]  a;
      logic [15:0] d;
      logic [15:0] exp_rd;
      int          exp_waits;
      logic        exp_err;
   } vec_t;

   vec_t tbl [8];

   initial begin
      logic [15:0] rd;
      int          waits, c0, c1, b2b_start;
      logic        e, done;

      rst = 1'b1; tgt = 0;
      p_sel = 1'b0; p_en = 1'b0; p_wr = 1'b0;
      p_addr = '0; p_wdata = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int t = 0; t < 3; t++) begin
         tgt = t;
         #1;
         chk("reset_ready", 32'(rdy), 32'(1'b0));
         chk("reset_rdata", 32'(rdata), 32'h0);
`ifdef APB_SLV_PSLVERR_EN
         chk("reset_slverr", 32'(err), 32'(1'b0));
`endif
      end

      tbl[0] = '{0, 1'b0, 3'd2, 16'h0000, 16'h0000, 0, 1'b0};
      tbl[1] = '{0, 1'b1, 3'd4, 16'hA5C3, 16'h0000, 0, 1'b0};
      tbl[2] = '{0, 1'b0, 3'd4, 16'h0000, 16'hA5C3, 0, 1'b0};
      tbl[3] = '{1, 1'b1, 3'd1, 16'h1234, 16'h0000, 3, 1'b0};
      tbl[4] = '{1, 1'b0, 3'd1, 16'h0000, 16'h1234, 3, 1'b0};
      tbl[5] = '{0, 1'b1, 3'd7, 16'hFFFF, 16'h0000, 0, 1'b1};
      tbl[6] = '{0, 1'b0, 3'd7, 16'h0000, 16'h0000, 0, 1'b1};
      tbl[7] = '{2, 1'b0, 3'd0, 16'h0000, 16'h0000, 2, 1'b0};

      b2b_start = 0;
      for (int i = 0; i < 8; i++) begin
         xfer(tbl[i].t, tbl[i].w, tbl[i].a, tbl[i].d,
              rd, waits, e, done, c0, c1);
         if (i == 1) b2b_start = c0;
         chk($sformatf("tbl%0d_done", i), 32'(done), 32'(1'b1));
         chk($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
         chk($sformatf("tbl%0d_waits", i), 32'(waits),
             32'(tbl[i].exp_waits));
`ifdef APB_SLV_PSLVERR_EN
         chk($sformatf("tbl%0d_slverr", i), 32'(e), 32'(tbl[i].exp_err));
`endif
         if (i == 2) chk("b2b_cycles", 32'(c1 - b2b_start), 32'd4);
         if (tbl[i].w && tbl[i].a < 6) mem[tbl[i].t][tbl[i].a] = tbl[i].d;
      end
      idle();

      // Penable without a setup phase must be ignored
      @(negedge clk);
      tgt = 0; p_sel = 1'b1; p_en = 1'b1; p_wr = 1'b1;
      p_addr = 3'd5; p_wdata = 16'h7777;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("noset_ready", 32'(rdy), 32'(1'b0));
      end
      idle();
      run(0, 1'b0, 3'd5, 16'h0);

      // Abort: Pselx dropped in the first access cycle
      @(negedge clk);
      tgt = 2; p_sel = 1'b1; p_en = 1'b0; p_wr = 1'b1;
      p_addr = 3'd0; p_wdata = 16'h5555;
      @(negedge clk);
      chk("abort_ready", 32'(rdy), 32'(1'b0));
      p_sel = 1'b0;
      @(negedge clk);
      chk("abort_idle", 32'(rdy), 32'(1'b0));
      run(2, 1'b0, 3'd0, 16'h0);
      idle();

      // Reset during a stalled write
      @(negedge clk);
      tgt = 1; p_sel = 1'b1; p_en = 1'b0; p_wr = 1'b1;
      p_addr = 3'd3; p_wdata = 16'hBEEF;
      @(negedge clk);
      p_en = 1'b1;
      @(negedge clk);
      chk("rst_stall", 32'(rdy), 32'(1'b0));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; p_sel = 1'b0; p_en = 1'b0;
      model_reset();
      chk("rst_idle", 32'(rdy), 32'(1'b0));
      run(1, 1'b0, 3'd3, 16'h0);
      run(0, 1'b0, 3'd4, 16'h0);
      idle();

      for (int n = 0; n < 300; n++) begin
         run($urandom_range(0, 2), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 16'($urandom));
         if ($urandom_range(0, 3) == 0) idle();
      end
      idle();
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
